// File: rtl/synth_pkg.sv
// Shared widths, voice/FSM state types and the note event record for the voice allocator.
// Also holds the lowest-set-bit helper used for free-slot and retrigger selection.
package synth_pkg;
  localparam int NUM_VOICES = 4;
  localparam int NOTE_W     = 7;
  localparam int VEL_W      = 7;
  localparam int IDX_W      = $clog2(NUM_VOICES);
  localparam int CNT_W      = $clog2(NUM_VOICES + 1);

  typedef enum logic [1:0] {IDLE, HELD, RELEASE} voice_state_t;
  typedef enum logic [1:0] {WAIT, SEARCH, COMMIT} alloc_state_t;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  velocity;
  } note_event_t;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_VOICES-1:0] vec);
    lowest_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (vec[i]) lowest_idx = IDX_W'(i);
    end
  endfunction
endpackage

// File: rtl/voice_age_tracker.sv
// Age ranks per voice (0 newest); a touch makes a voice newest, o_oldest_idx picks the
// highest rank within i_mask combinationally. Rank update lands on the edge after the touch.
module voice_age_tracker
  import synth_pkg::*;
(
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             i_touch_vld,
  input  logic [IDX_W-1:0]                 i_touch_idx,
  input  logic [NUM_VOICES-1:0]            i_mask,
  output logic [NUM_VOICES-1:0][IDX_W-1:0] o_rank,
  output logic [IDX_W-1:0]                 o_oldest_idx
);
  logic [NUM_VOICES-1:0][IDX_W-1:0] r_rank;
  logic [IDX_W-1:0]                 w_top;
  logic                             w_any;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) r_rank[i] <= IDX_W'(i);
    end else if (i_touch_vld) begin
      // Only voices younger than the touched one age, so ranks stay a permutation.
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == i_touch_idx)              r_rank[i] <= '0;
        else if (r_rank[i] < r_rank[i_touch_idx]) r_rank[i] <= r_rank[i] + 1'b1;
      end
    end
  end

  always_comb begin
    o_oldest_idx = '0;
    w_top        = '0;
    w_any        = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (i_mask[i] && (!w_any || r_rank[i] > w_top)) begin
        o_oldest_idx = IDX_W'(i);
        w_top        = r_rank[i];
        w_any        = 1'b1;
      end
    end
  end

  assign o_rank = r_rank;
endmodule

// File: rtl/voice_allocator.sv
// Polyphony allocator: accept -> search -> commit, voice outputs update 2 edges after acceptance.
// evt_ready drops for the two cycles an event is in flight, giving one event per 3 cycles.
module voice_allocator
  import synth_pkg::*;
(
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              evt_valid,
  output logic                              evt_ready,
  input  logic                              evt_on,
  input  logic [NOTE_W-1:0]                 evt_note,
  input  logic [VEL_W-1:0]                  evt_velocity,
  input  logic [NUM_VOICES-1:0]             voice_done,
  output logic [NUM_VOICES-1:0]             voice_gate,
  output logic [NUM_VOICES-1:0]             voice_trigger,
  output logic [NUM_VOICES-1:0]             voice_enable,
  output logic [NUM_VOICES-1:0][NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0][VEL_W-1:0]  voice_velocity,
  output logic [CNT_W-1:0]                  active_count
);
  alloc_state_t                     r_fsm;
  note_event_t                      r_evt;
  logic [IDX_W-1:0]                 r_tgt;
  logic [NUM_VOICES-1:0]            r_off_vec;
  voice_state_t                     r_state [NUM_VOICES];
  logic [NUM_VOICES-1:0][NOTE_W-1:0] r_note;
  logic [NUM_VOICES-1:0][VEL_W-1:0]  r_vel;
  logic [NUM_VOICES-1:0]            r_trig;

  logic [NUM_VOICES-1:0]            w_match, w_free, w_rel, w_held, w_off_vec, w_steal_mask;
  logic [IDX_W-1:0]                 w_oldest, w_tgt;
  logic [NUM_VOICES-1:0][IDX_W-1:0] w_rank;
  logic                             w_touch;

  always_comb begin
    w_match = '0; w_free = '0; w_rel = '0; w_held = '0; w_off_vec = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_free[i]    = (r_state[i] == IDLE);
      w_held[i]    = (r_state[i] == HELD);
      w_rel[i]     = (r_state[i] == RELEASE);
      w_match[i]   = (r_state[i] != IDLE) && (r_note[i] == r_evt.note);
      w_off_vec[i] = (r_state[i] == HELD) && (r_note[i] == r_evt.note);
    end
  end

  // Steal prefers the oldest releasing voice; only when none is releasing does a held one go.
  assign w_steal_mask = (|w_rel) ? w_rel : w_held;
  assign w_tgt   = (|w_match) ? lowest_idx(w_match) :
                   (|w_free)  ? lowest_idx(w_free)  : w_oldest;
  assign w_touch = (r_fsm == COMMIT) && r_evt.on;

  voice_age_tracker u_age (
    .clock        (clock),
    .reset        (reset),
    .i_touch_vld  (w_touch),
    .i_touch_idx  (r_tgt),
    .i_mask       (w_steal_mask),
    .o_rank       (w_rank),
    .o_oldest_idx (w_oldest)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fsm     <= WAIT;
      r_evt     <= '0;
      r_tgt     <= '0;
      r_off_vec <= '0;
      r_note    <= '0;
      r_vel     <= '0;
      r_trig    <= '0;
      for (int i = 0; i < NUM_VOICES; i++) r_state[i] <= IDLE;
    end else begin
      r_trig <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (r_state[i] == RELEASE && voice_done[i]) r_state[i] <= IDLE;
      end
      case (r_fsm)
        WAIT: begin
          if (evt_valid) begin
            r_evt <= '{on: evt_on, note: evt_note, velocity: evt_velocity};
            r_fsm <= SEARCH;
          end
        end
        SEARCH: begin
          r_tgt     <= w_tgt;
          r_off_vec <= w_off_vec;
          r_fsm     <= COMMIT;
        end
        COMMIT: begin
          // Written after the release-done loop so a same-cycle commit overrides it.
          if (r_evt.on) begin
            r_state[r_tgt] <= HELD;
            r_note[r_tgt]  <= r_evt.note;
            r_vel[r_tgt]   <= r_evt.velocity;
            r_trig[r_tgt]  <= 1'b1;
          end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (r_off_vec[i]) r_state[i] <= RELEASE;
            end
          end
          r_fsm <= WAIT;
        end
        default: r_fsm <= WAIT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VOICES; i++)
        for (int j = i + 1; j < NUM_VOICES; j++)
          assert (w_rank[i] != w_rank[j]);
    end
  end

  always_comb begin
    voice_gate   = '0;
    voice_enable = '0;
    active_count = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_gate[i]   = (r_state[i] == HELD);
      voice_enable[i] = (r_state[i] != IDLE);
      if (r_state[i] != IDLE) active_count = active_count + 1'b1;
    end
  end

  assign evt_ready      = (r_fsm == WAIT) && !reset;
  assign voice_trigger  = r_trig;
  assign voice_note     = r_note;
  assign voice_velocity = r_vel;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation priority, steal order, retrigger,
// release completion, collisions with commit, and reset mid-event.
module tb_voice_allocator;
  logic             clock = 1'b0;
  logic             reset;
  logic             evt_valid, evt_ready, evt_on;
  logic [6:0]       evt_note, evt_velocity;
  logic [3:0]       voice_done, voice_gate, voice_trigger, voice_enable;
  logic [3:0][6:0]  voice_note, voice_velocity;
  logic [2:0]       active_count;
  int               tests = 0;
  int               fails = 0;

  always #5 clock = ~clock;

  voice_allocator dut (
    .clock          (clock),
    .reset          (reset),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_on         (evt_on),
    .evt_note       (evt_note),
    .evt_velocity   (evt_velocity),
    .voice_done     (voice_done),
    .voice_gate     (voice_gate),
    .voice_trigger  (voice_trigger),
    .voice_enable   (voice_enable),
    .voice_note     (voice_note),
    .voice_velocity (voice_velocity),
    .active_count   (active_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Presents one event and returns 1 ns after the commit edge (E2).
  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel);
    int n = 0;
    @(negedge clock);
    while (!evt_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!evt_ready) begin
      tests++; fails++;
      $display("FAIL send_ready_timeout got=%b exp=1", evt_ready);
    end
    evt_valid = 1'b1; evt_on = on; evt_note = note; evt_velocity = vel;
    @(posedge clock); #1 evt_valid = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    evt_valid = 1'b0; evt_on = 1'b0; evt_note = '0; evt_velocity = '0; voice_done = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests++; if (evt_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_in_reset got=%b exp=0", evt_ready); end
    reset = 1'b0; #1;
    tests++; if (evt_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after got=%b exp=1", evt_ready); end
    tests++; if (voice_gate !== 4'b0000) begin fails++; $display("FAIL reset_gate got=%b exp=0000", voice_gate); end
    tests++; if (voice_enable !== 4'b0000) begin fails++; $display("FAIL reset_enable got=%b exp=0000", voice_enable); end
    tests++; if (voice_trigger !== 4'b0000) begin fails++; $display("FAIL reset_trigger got=%b exp=0000", voice_trigger); end
    tests++; if (active_count !== 3'd0) begin fails++; $display("FAIL reset_active got=%0d exp=0", active_count); end
    tests++; if (voice_note !== 28'd0 || voice_velocity !== 28'd0) begin fails++; $display("FAIL reset_note_vel got=%h/%h exp=0/0", voice_note, voice_velocity); end
  endtask

  task automatic test_first_note();
    @(negedge clock);
    evt_valid = 1'b1; evt_on = 1'b1; evt_note = 7'd60; evt_velocity = 7'd100;
    @(posedge clock); #1 evt_valid = 1'b0;
    tests++; if (evt_ready !== 1'b0) begin fails++; $display("FAIL first_ready_e0 got=%b exp=0", evt_ready); end
    @(posedge clock); #1;
    tests++; if (evt_ready !== 1'b0 || voice_gate !== 4'b0000) begin fails++; $display("FAIL first_e1 ready=%b gate=%b exp=0/0000", evt_ready, voice_gate); end
    @(posedge clock); #1;
    tests++; if (evt_ready !== 1'b1) begin fails++; $display("FAIL first_ready_e2 got=%b exp=1", evt_ready); end
    tests++; if (voice_gate !== 4'b0001) begin fails++; $display("FAIL first_gate got=%b exp=0001", voice_gate); end
    tests++; if (voice_trigger !== 4'b0001) begin fails++; $display("FAIL first_trigger got=%b exp=0001", voice_trigger); end
    tests++; if (voice_note[0] !== 7'd60 || voice_velocity[0] !== 7'd100) begin fails++; $display("FAIL first_note_vel got=%0d/%0d exp=60/100", voice_note[0], voice_velocity[0]); end
    tests++; if (active_count !== 3'd1) begin fails++; $display("FAIL first_active got=%0d exp=1", active_count); end
    @(posedge clock); #1;
    tests++; if (voice_trigger !== 4'b0000) begin fails++; $display("FAIL first_trigger_pulse got=%b exp=0000", voice_trigger); end
  endtask

  task automatic test_steal_held();
    send(1'b1, 7'd62, 7'd10);
    tests++; if (voice_trigger !== 4'b0010) begin fails++; $display("FAIL fill_v1_trigger got=%b exp=0010", voice_trigger); end
    send(1'b1, 7'd64, 7'd20);
    send(1'b1, 7'd65, 7'd30);
    tests++; if (active_count !== 3'd4 || voice_gate !== 4'b1111) begin fails++; $display("FAIL fill_full active=%0d gate=%b exp=4/1111", active_count, voice_gate); end
    send(1'b1, 7'd67, 7'd50);
    tests++; if (voice_trigger !== 4'b0001) begin fails++; $display("FAIL steal_held_trigger got=%b exp=0001", voice_trigger); end
    tests++; if (voice_note[0] !== 7'd67 || voice_velocity[0] !== 7'd50) begin fails++; $display("FAIL steal_held_note got=%0d/%0d exp=67/50", voice_note[0], voice_velocity[0]); end
    tests++; if (voice_enable !== 4'b1111 || voice_note[1] !== 7'd62) begin fails++; $display("FAIL steal_held_others enable=%b note1=%0d exp=1111/62", voice_enable, voice_note[1]); end
  endtask

  task automatic test_release_steal();
    send(1'b0, 7'd62, 7'd0);
    tests++; if (voice_gate !== 4'b1101 || voice_enable !== 4'b1111) begin fails++; $display("FAIL off62 gate=%b enable=%b exp=1101/1111", voice_gate, voice_enable); end
    tests++; if (voice_trigger !== 4'b0000 || active_count !== 3'd4) begin fails++; $display("FAIL off62_trig trig=%b active=%0d exp=0000/4", voice_trigger, active_count); end
    send(1'b1, 7'd70, 7'd5);
    tests++; if (voice_trigger !== 4'b0010 || voice_note[1] !== 7'd70) begin fails++; $display("FAIL steal_rel trig=%b note1=%0d exp=0010/70", voice_trigger, voice_note[1]); end
    tests++; if (voice_gate !== 4'b1111) begin fails++; $display("FAIL steal_rel_gate got=%b exp=1111", voice_gate); end
    // Voice 3 releases while voice 2 is the oldest held: the releasing voice must go.
    send(1'b0, 7'd65, 7'd0);
    tests++; if (voice_gate !== 4'b0111) begin fails++; $display("FAIL off65_gate got=%b exp=0111", voice_gate); end
    send(1'b1, 7'd72, 7'd1);
    tests++; if (voice_trigger !== 4'b1000 || voice_note[3] !== 7'd72 || voice_note[2] !== 7'd64) begin fails++; $display("FAIL steal_rel_young trig=%b note3=%0d note2=%0d exp=1000/72/64", voice_trigger, voice_note[3], voice_note[2]); end
  endtask

  task automatic test_no_match();
    @(negedge clock);
    evt_valid = 1'b1; evt_on = 1'b0; evt_note = 7'd48; evt_velocity = 7'd0;
    @(posedge clock); #1 evt_valid = 1'b0;
    tests++; if (evt_ready !== 1'b0) begin fails++; $display("FAIL nomatch_ready_e0 got=%b exp=0", evt_ready); end
    @(posedge clock); #1;
    tests++; if (evt_ready !== 1'b0) begin fails++; $display("FAIL nomatch_ready_e1 got=%b exp=0", evt_ready); end
    @(posedge clock); #1;
    tests++; if (evt_ready !== 1'b1) begin fails++; $display("FAIL nomatch_ready_e2 got=%b exp=1", evt_ready); end
    tests++; if (voice_gate !== 4'b1111 || voice_enable !== 4'b1111 || voice_trigger !== 4'b0000 || active_count !== 3'd4) begin fails++; $display("FAIL nomatch_outputs gate=%b en=%b trig=%b act=%0d exp=1111/1111/0000/4", voice_gate, voice_enable, voice_trigger, active_count); end
  endtask

  task automatic test_retrigger();
    apply_reset();
    send(1'b1, 7'd60, 7'd100);
    send(1'b0, 7'd60, 7'd0);
    tests++; if (voice_gate !== 4'b0000 || voice_enable !== 4'b0001 || active_count !== 3'd1) begin fails++; $display("FAIL retrig_release gate=%b en=%b act=%0d exp=0000/0001/1", voice_gate, voice_enable, active_count); end
    send(1'b1, 7'd60, 7'd90);
    tests++; if (voice_trigger !== 4'b0001) begin fails++; $display("FAIL retrig_trigger got=%b exp=0001", voice_trigger); end
    tests++; if (voice_gate !== 4'b0001 || voice_velocity[0] !== 7'd90 || active_count !== 3'd1) begin fails++; $display("FAIL retrig_state gate=%b vel=%0d act=%0d exp=0001/90/1", voice_gate, voice_velocity[0], active_count); end
  endtask

  task automatic test_done();
    @(negedge clock); voice_done = 4'b0001;
    @(posedge clock); #1 voice_done = 4'b0000;
    tests++; if (voice_gate !== 4'b0001 || voice_enable !== 4'b0001) begin fails++; $display("FAIL done_in_held gate=%b en=%b exp=0001/0001", voice_gate, voice_enable); end
    send(1'b0, 7'd60, 7'd0);
    @(negedge clock);
    evt_valid = 1'b1; evt_on = 1'b1; evt_note = 7'd60; evt_velocity = 7'd33;
    @(posedge clock); #1 evt_valid = 1'b0;
    @(posedge clock); #1 voice_done = 4'b0001;
    @(posedge clock); #1 voice_done = 4'b0000;
    tests++; if (voice_gate !== 4'b0001 || voice_trigger !== 4'b0001 || voice_velocity[0] !== 7'd33) begin fails++; $display("FAIL done_vs_commit gate=%b trig=%b vel=%0d exp=0001/0001/33", voice_gate, voice_trigger, voice_velocity[0]); end
    @(posedge clock); #1;
    tests++; if (voice_enable !== 4'b0001) begin fails++; $display("FAIL done_vs_commit_after en=%b exp=0001", voice_enable); end
    send(1'b0, 7'd60, 7'd0);
    @(negedge clock); voice_done = 4'b0001;
    @(posedge clock); #1 voice_done = 4'b0000;
    tests++; if (voice_enable !== 4'b0000 || active_count !== 3'd0) begin fails++; $display("FAIL done_idle en=%b act=%0d exp=0000/0", voice_enable, active_count); end
    tests++; if (voice_note[0] !== 7'd60 || voice_velocity[0] !== 7'd33) begin fails++; $display("FAIL done_keep_note got=%0d/%0d exp=60/33", voice_note[0], voice_velocity[0]); end
  endtask

  task automatic test_reset_search();
    send(1'b1, 7'd40, 7'd7);
    tests++; if (voice_gate !== 4'b0001) begin fails++; $display("FAIL rs_setup_gate got=%b exp=0001", voice_gate); end
    @(negedge clock);
    evt_valid = 1'b1; evt_on = 1'b1; evt_note = 7'd50; evt_velocity = 7'd9;
    @(posedge clock); #1 evt_valid = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    tests++; if (evt_ready !== 1'b0 || voice_enable !== 4'b0000) begin fails++; $display("FAIL rs_in_reset ready=%b en=%b exp=0/0000", evt_ready, voice_enable); end
    @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      tests++; if (voice_trigger !== 4'b0000 || voice_gate !== 4'b0000) begin fails++; $display("FAIL rs_no_commit cyc=%0d trig=%b gate=%b exp=0000/0000", k, voice_trigger, voice_gate); end
    end
    tests++; if (evt_ready !== 1'b1 || active_count !== 3'd0 || voice_note[0] !== 7'd0) begin fails++; $display("FAIL rs_final ready=%b act=%0d note0=%0d exp=1/0/0", evt_ready, active_count, voice_note[0]); end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_steal_held();
    test_release_steal();
    test_no_match();
    test_retrigger();
    test_done();
    test_reset_search();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
